// File: rtl/rv_decode_stage.sv
// RV32I decode stage: registered decode of all base formats with valid/ready on both sides.
// SKID=1 adds a second entry so in_ready comes straight from a flop.
module rv_decode_stage #(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5,
  parameter int SKID  = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [RF_AW-1:0] out_rd_idx,
  output logic [RF_AW-1:0] out_rs1_idx,
  output logic [RF_AW-1:0] out_rs2_idx,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_rf_we,
  output logic             out_illegal,
  output logic [9:0]       out_funct,
  output logic [CNT_W-1:0] dec_count
);

  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
                         FMT_U = 3'd4, FMT_J = 3'd5, FMT_NONE = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [RF_AW-1:0] rd;
    logic [RF_AW-1:0] rs1;
    logic [RF_AW-1:0] rs2;
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             rf_we;
    logic             illegal;
    logic [9:0]       funct;
  } bundle_t;

  function automatic bundle_t decode(input logic [31:0] instr, input logic [XLEN-1:0] pc);
    bundle_t            b;
    logic signed [31:0] imm32;
    logic [2:0]         fmt;
    b       = '0;
    b.pc    = pc;
    b.funct = {instr[31:25], instr[14:12]};
    fmt     = FMT_NONE;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:0])
        7'b0110111, 7'b0010111:                         fmt = FMT_U;
        7'b1101111:                                     fmt = FMT_J;
        7'b1100011:                                     fmt = FMT_B;
        7'b0100011:                                     fmt = FMT_S;
        7'b0110011:                                     fmt = FMT_R;
        7'b1100111, 7'b0000011, 7'b0010011,
        7'b0001111, 7'b1110011:                         fmt = FMT_I;
        default:                                        fmt = FMT_NONE;
      endcase
    end
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    b.fmt     = fmt;
    b.illegal = (fmt == FMT_NONE);
    b.imm     = XLEN'(imm32);
    if (fmt == FMT_R || fmt == FMT_I || fmt == FMT_U || fmt == FMT_J)
      b.rd = RF_AW'(instr[11:7]);
    if (fmt == FMT_R || fmt == FMT_I || fmt == FMT_S || fmt == FMT_B)
      b.rs1 = RF_AW'(instr[19:15]);
    if (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B)
      b.rs2 = RF_AW'(instr[24:20]);
    b.rf_we = (b.rd != '0);
    return b;
  endfunction

  bundle_t          new_b;
  bundle_t          out_q, out_d, skid_q, skid_d;
  logic             out_vld_q, out_vld_d, skid_full_q, skid_full_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, out_fire, out_free;

  assign new_b    = decode(in_instr, in_pc);
  assign in_ready = (SKID != 0) ? !skid_full_q : (!out_vld_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_vld_q && out_ready;
  assign out_free = !out_vld_q || out_ready;

  // Skid never fills while accepting: in_ready is low whenever it is full.
  always_comb begin
    out_d       = out_q;
    out_vld_d   = out_vld_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    cnt_d       = cnt_q + CNT_W'(out_fire);
    if (out_free) begin
      if (skid_full_q) begin
        out_d       = skid_q;
        out_vld_d   = 1'b1;
        skid_full_d = 1'b0;
      end else begin
        out_vld_d = accept;
        if (accept) out_d = new_b;
      end
    end else if (accept && SKID != 0) begin
      skid_d      = new_b;
      skid_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= '0;
      skid_q      <= '0;
      out_vld_q   <= 1'b0;
      skid_full_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_q       <= out_d;
      skid_q      <= skid_d;
      out_vld_q   <= out_vld_d;
      skid_full_q <= skid_full_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid   = out_vld_q;
  assign out_pc      = out_q.pc;
  assign out_rd_idx  = out_q.rd;
  assign out_rs1_idx = out_q.rs1;
  assign out_rs2_idx = out_q.rs2;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_rf_we   = out_q.rf_we;
  assign out_illegal = out_q.illegal;
  assign out_funct   = out_q.funct;
  assign dec_count   = cnt_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench: u_skid (SKID=1) and u_flat (SKID=0, 4-bit counter) share one stimulus set.
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        ir1, v1, we1, ill1;
  logic [31:0] pc1, imm1, dc1;
  logic [4:0]  rd1, rs1_1, rs2_1;
  logic [2:0]  fmt1;
  logic [9:0]  fn1;

  logic        ir0, v0, we0, ill0;
  logic [31:0] pc0, imm0;
  logic [3:0]  dc0;
  logic [4:0]  rd0, rs1_0, rs2_0;
  logic [2:0]  fmt0;
  logic [9:0]  fn0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rv_decode_stage #(.XLEN(32), .RF_AW(5), .SKID(1), .CNT_W(32)) u_skid (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .in_instr(in_instr),
    .in_pc(in_pc), .out_valid(v1), .out_ready(out_ready), .out_pc(pc1), .out_rd_idx(rd1),
    .out_rs1_idx(rs1_1), .out_rs2_idx(rs2_1), .out_imm(imm1), .out_fmt(fmt1),
    .out_rf_we(we1), .out_illegal(ill1), .out_funct(fn1), .dec_count(dc1));

  rv_decode_stage #(.XLEN(32), .RF_AW(5), .SKID(0), .CNT_W(4)) u_flat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .in_instr(in_instr),
    .in_pc(in_pc), .out_valid(v0), .out_ready(out_ready), .out_pc(pc0), .out_rd_idx(rd0),
    .out_rs1_idx(rs1_0), .out_rs2_idx(rs2_0), .out_imm(imm0), .out_fmt(fmt0),
    .out_rf_we(we0), .out_illegal(ill0), .out_funct(fn0), .dec_count(dc0));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Send one instruction to the skid DUT with out_ready high and check the bundle next cycle.
  task automatic dec(input logic [31:0] instr, input logic [31:0] pc, input int rd, input int rs1,
                     input int rs2, input logic [31:0] imm, input int fmt, input int we, input int ill);
    string t;
    t = $sformatf("%08h", instr);
    @(negedge clk);
    in_valid = 1'b1; in_instr = instr; in_pc = pc; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({t, "_vld"}, 64'(v1), 64'd1);
    check({t, "_pc"}, 64'(pc1), 64'(pc));
    check({t, "_rd"}, 64'(rd1), 64'(rd));
    check({t, "_rs1"}, 64'(rs1_1), 64'(rs1));
    check({t, "_rs2"}, 64'(rs2_1), 64'(rs2));
    check({t, "_imm"}, 64'(imm1), 64'(imm));
    check({t, "_fmt"}, 64'(fmt1), 64'(fmt));
    check({t, "_we"}, 64'(we1), 64'(we));
    check({t, "_ill"}, 64'(ill1), 64'(ill));
    check({t, "_funct"}, 64'(fn1), 64'({instr[31:25], instr[14:12]}));
  endtask

  // Stream n ADDI xk+1 instructions into one DUT; outputs must appear in order without loss.
  task automatic stream(input int which, input int n, input int stall, input bit rnd);
    int acc = 0;
    int got = 0;
    logic ir, ov;
    logic [4:0]  rd;
    logic [31:0] pc;
    for (int cyc = 0; cyc < 300 && got < n; cyc++) begin
      @(negedge clk);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : (cyc >= stall);
      in_valid  = (acc < n);
      in_instr  = 32'h0000_0013 | (32'(acc + 1) << 7);
      in_pc     = 32'h200 + 32'(4 * acc);
      #1;
      ir = which ? ir1 : ir0;
      ov = which ? v1  : v0;
      rd = which ? rd1 : rd0;
      pc = which ? pc1 : pc0;
      if (which == 1 && stall == 3 && cyc == 2) begin
        check("skid_ready_drop", 64'(ir), 64'd0);
        check("skid_accepts", 64'(acc), 64'd2);
      end
      if (in_valid && ir) acc++;
      if (ov && out_ready) begin
        check($sformatf("order_rd_%0d", got), 64'(rd), 64'(got + 1));
        check($sformatf("order_pc_%0d", got), 64'(pc), 64'(32'h200 + 32'(4 * got)));
        got++;
      end
    end
    check("stream_done", 64'(got), 64'(n));
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", 64'(v1), 64'd0);
    check("rst_imm", 64'(imm1), 64'd0);
    check("rst_cnt", 64'(dc1), 64'd0);
    check("rst_cnt4", 64'(dc0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 64'(ir1), 64'd1);

    //     instr         pc      rd rs1 rs2 imm           fmt we ill
    dec(32'h123452B7, 32'h100, 5, 0, 0, 32'h12345000, 4, 1, 0);
    dec(32'hFFDFF0EF, 32'h104, 1, 0, 0, 32'hFFFFFFFC, 5, 1, 0);
    dec(32'hFFF00013, 32'h108, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 0);
    dec(32'h0021A423, 32'h10C, 0, 3, 2, 32'h00000008, 2, 0, 0);
    dec(32'hFE208EE3, 32'h110, 0, 1, 2, 32'hFFFFFFFC, 3, 0, 0);
    dec(32'h004280E7, 32'h114, 1, 5, 0, 32'h00000004, 1, 1, 0);
    dec(32'h00000000, 32'h118, 0, 0, 0, 32'h00000000, 6, 0, 1);
    dec(32'hFFFFFFFF, 32'h11C, 0, 0, 0, 32'h00000000, 6, 0, 1);

    do_reset();
    stream(1, 4, 3, 1'b0);
    check("skid_cnt", 64'(dc1), 64'd4);

    // Fill both entries, then reset while stalled.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h300;
    @(negedge clk);
    in_instr = 32'h00200113; in_pc = 32'h304;
    @(posedge clk); #1;
    check("full_vld", 64'(v1), 64'd1);
    check("full_ready", 64'(ir1), 64'd0);
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_vld", 64'(v1), 64'd0);
    check("midrst_cnt", 64'(dc1), 64'd0);
    check("midrst_ready", 64'(ir1), 64'd1);
    check("midrst_rd", 64'(rd1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_reset();
    stream(0, 6, 0, 1'b1);
    check("flat_cnt6", 64'(dc0), 64'd6);
    stream(0, 10, 0, 1'b0);
    check("flat_cnt_wrap", 64'(dc0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
Registered RV32I decode pipeline stage, the successor to the combinational LUI/AUIPC/JAL decoder. It decodes all base formats (R/I/S/B/U/J) into register indices, a sign-extended immediate and control fields. It sits between fetch and execute with valid/ready handshakes on both sides, an optional skid buffer, and an illegal-instruction flag. Decode latency is one cycle.

Parameters:
XLEN, 32, datapath/immediate width; must be >= 32; immediates sign-extend to XLEN.
RF_AW, 5, register index width; indices are instr fields zero-extended/truncated to RF_AW.
SKID, 1, 1 = two-entry skid buffer (in_ready registered); 0 = single output register (in_ready combinational).
CNT_W, 32, width of decoded-instruction counter.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage accepts instruction this cycle
in_instr  in  32  instruction word
in_pc  in  XLEN  PC of instruction
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
out_pc  out  XLEN  PC passed through
out_rd_idx / out_rs1_idx / out_rs2_idx  out  RF_AW each  register indices, 0 when unused
out_imm  out  XLEN  sign-extended immediate, 0 for R-type
out_fmt  out  3  0=R 1=I 2=S 3=B 4=U 5=J 6=none
out_rf_we  out  1  writes rd
out_illegal  out  1  unsupported opcode
out_funct  out  10  {funct7, funct3} raw
dec_count  out  CNT_W  completed output handshakes

Behaviour:
- Reset (rst_n=0 at posedge): out_valid=0, all out_* data=0, dec_count=0, skid entry empty; in_ready=1 on the first cycle after reset. Reset mid-transfer discards both entries; no handshake completes in the reset cycle.
- Accept: in_valid && in_ready at posedge. Output handshake: out_valid && out_ready.
- Latency: bundle appears on out_* the cycle after acceptance. Out data are stable while out_valid && !out_ready.
- SKID=0: in_ready = !out_valid || out_ready. Back-to-back throughput 1/cycle.
- SKID=1: in_ready = !skid_full (registered, no comb path from out_ready). Accept while output is stalled -> entry to skid, skid_full=1. When output drains, skid moves to output the same edge; a simultaneous new input goes to skid only if skid was empty. Order is strictly FIFO; no drop, no duplication.
- Opcodes: LUI 0110111 U, AUIPC 0010111 U, JAL 1101111 J, JALR 1100111 I, BRANCH 1100011 B, LOAD 0000011 I, STORE 0100011 S, OP-IMM 0010011 I, OP 0110011 R, MISC-MEM 0001111 I, SYSTEM 1110011 I. Any other opcode, or instr[1:0]!=2'b11 -> illegal.
- Immediates: I={instr[31:20]}; S={instr[31:25],instr[11:7]}; B={instr[31],instr[7],instr[30:25],instr[11:8],0}; U={instr[31:12],12'b0}; J={instr[31],instr[19:12],instr[20],instr[30:21],0}. All sign-extend from bit 31 of the instruction to XLEN.
- Indices: rd for R/I/U/J; rs1 for R/I/S/B (0 for LUI/AUIPC/JAL); rs2 for R/S/B; else 0.
- rf_we = format in {R,I,U,J} && rd!=0 && !illegal. BRANCH/STORE -> 0. MISC-MEM/SYSTEM -> rf_we follows rd (no special-casing).
- Illegal: out_illegal=1, fmt=6, rf_we=0, imm=0, indices=0, pc and funct still passed. The bundle still flows through the handshake.
- dec_count increments by 1 per output handshake and wraps modulo 2^CNT_W.

Test Plan:
- LUI x5,0x12345 (0x123452B7), pc=0x100 -> next cycle out_valid=1, rd=5, rs1=rs2=0, imm=0x12345000, fmt=4, rf_we=1, out_pc=0x100.
- JAL x1,-4 (0xFFDFF0EF) -> imm=0xFFFFFFFC, fmt=5, rd=1, rf_we=1. ADDI x0,x0,-1 (0xFFF00013) -> imm=0xFFFFFFFF, rf_we=0 (rd=0).
- SW x2,8(x3) (0x0021A423) -> fmt=2, rs1=3, rs2=2, imm=8, rd=0, rf_we=0. Instructions 0x00000000 and 0xFFFFFFFF -> illegal=1, rf_we=0, fmt=6.
- SKID=1: stream 4 instrs with out_ready low for 3 cycles -> in_ready drops after 2 accepts, no loss, output order preserved, dec_count=4 at end. Repeat with SKID=0 and random out_ready.
- Assert rst_n low while out_valid=1 and skid full -> next cycle out_valid=0, dec_count=0, in_ready=1. Preload CNT_W=4 counter via 16 handshakes -> wraps to 0.
